// File: rtl/gpr_writeback_queue.sv
//------------------------------------------------------------------------------
// gpr_writeback_queue : multi-port FIFO that batches GPR writebacks, draining
//                       up to NUM_WR_PRTS hazard-free entries per cycle.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module gpr_writeback_queue #(
   parameter int REG_WIDTH   = 32,
   parameter int NUM_REGS    = 32,
   parameter int NUM_WR_PRTS = 4,
   parameter int NUM_ENQ     = 2,
   parameter int DEPTH       = 16
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_ENQ-1:0]                        in_vld,
   input  logic [NUM_ENQ*$clog2(NUM_REGS)-1:0]       in_trgt,
   input  logic [NUM_ENQ*REG_WIDTH-1:0]              in_dat,
   output logic                                      in_rdy,
   input  logic                                      hold,
   output logic [NUM_WR_PRTS-1:0]                    we,
   output logic [NUM_WR_PRTS*$clog2(NUM_REGS)-1:0]   wr_trgt,
   output logic [NUM_WR_PRTS*REG_WIDTH-1:0]          wr_dat,
   output logic [NUM_REGS-1:0]                       pending,
   output logic [$clog2(DEPTH+1)-1:0]                count,
   output logic                                      empty
);

   localparam int c_tw = $clog2(NUM_REGS);
   localparam int c_pw = $clog2(DEPTH);
   localparam int c_cw = $clog2(DEPTH+1);
   localparam int c_kw = $clog2(NUM_WR_PRTS+1);
   localparam int c_ew = $clog2(NUM_ENQ+1);

   logic [c_tw-1:0]      r_trgt_mem [DEPTH];
   logic [REG_WIDTH-1:0] r_dat_mem  [DEPTH];
   logic [c_pw-1:0]      r_head;
   logic [c_pw-1:0]      r_tail;
   logic [c_cw-1:0]      r_count;

   logic                 w_rdy;
   logic                 w_stop;
   logic [c_kw-1:0]      w_k;
   logic [c_ew-1:0]      w_enq_n;
   logic [c_pw-1:0]      w_slot   [NUM_ENQ];
   logic [c_pw-1:0]      w_rd_idx [NUM_WR_PRTS];

   // Credit is based on registered occupancy only; a same-cycle drain never frees space.
   assign w_rdy  = (c_cw'(DEPTH) - r_count) >= c_cw'(NUM_ENQ);
   assign in_rdy = w_rdy;
   assign count  = r_count;
   assign empty  = (r_count == '0);

   always_comb begin
      for (int j = 0; j < NUM_WR_PRTS; j++) begin
         w_rd_idx[j] = r_head + c_pw'(j);
      end
   end

   // Valid ports are packed densely from the tail so sparse requests leave no holes.
   always_comb begin
      w_enq_n = '0;
      for (int i = 0; i < NUM_ENQ; i++) begin
         w_slot[i] = r_tail + c_pw'(w_enq_n);
         if (w_rdy && in_vld[i]) begin
            w_enq_n = w_enq_n + c_ew'(1);
         end
      end
   end

   // Drain group stops at the first entry repeating an earlier target in the run,
   // so two writes to one register never land at the same edge.
   always_comb begin
      w_k     = '0;
      w_stop  = 1'b0;
      we      = '0;
      wr_trgt = '0;
      wr_dat  = '0;
      for (int j = 0; j < NUM_WR_PRTS; j++) begin
         if (hold || (c_cw'(j) >= r_count)) begin
            w_stop = 1'b1;
         end
         for (int l = 0; l < j; l++) begin
            if (r_trgt_mem[w_rd_idx[l]] == r_trgt_mem[w_rd_idx[j]]) begin
               w_stop = 1'b1;
            end
         end
         if (!w_stop) begin
            w_k                          = c_kw'(j + 1);
            we[j]                        = 1'b1;
            wr_trgt[j*c_tw +: c_tw]      = r_trgt_mem[w_rd_idx[j]];
            wr_dat[j*REG_WIDTH +: REG_WIDTH] = r_dat_mem[w_rd_idx[j]];
         end
      end
   end

   always_comb begin
      pending = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (c_cw'(c_pw'(c_pw'(e) - r_head)) < r_count) begin
            pending[r_trgt_mem[e]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + c_pw'(w_k);
         r_tail  <= r_tail + c_pw'(w_enq_n);
         r_count <= r_count + c_cw'(w_enq_n) - c_cw'(w_k);
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENQ; i++) begin
         if (!rst && w_rdy && in_vld[i]) begin
            r_trgt_mem[w_slot[i]] <= in_trgt[i*c_tw +: c_tw];
            r_dat_mem[w_slot[i]]  <= in_dat[i*REG_WIDTH +: REG_WIDTH];
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gpr_writeback_queue.sv
//------------------------------------------------------------------------------
// tb_gpr_writeback_queue : directed and randomized checks against a queue model.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_gpr_writeback_queue;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    in_vld;
   logic [9:0]    in_trgt;
   logic [63:0]   in_dat;
   logic          in_rdy;
   logic          hold;
   logic [3:0]    we;
   logic [19:0]   wr_trgt;
   logic [127:0]  wr_dat;
   logic [31:0]   pending;
   logic [4:0]    count;
   logic          empty;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0]  t;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];

   always #5 clk = ~clk;

   gpr_writeback_queue dut (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (in_vld),
      .in_trgt (in_trgt),
      .in_dat  (in_dat),
      .in_rdy  (in_rdy),
      .hold    (hold),
      .we      (we),
      .wr_trgt (wr_trgt),
      .wr_dat  (wr_dat),
      .pending (pending),
      .count   (count),
      .empty   (empty)
   );

   // Number of entries the model drains this cycle.
   function automatic int model_k(input bit h);
      int k = 0;
      if (h) return 0;
      for (int j = 0; j < 4 && j < mq.size(); j++) begin
         for (int l = 0; l < j; l++) begin
            if (mq[l].t == mq[j].t) return k;
         end
         k = j + 1;
      end
      return k;
   endfunction

   function automatic logic [31:0] model_pending();
      logic [31:0] p = '0;
      foreach (mq[i]) p[mq[i].t] = 1'b1;
      return p;
   endfunction

   // Advance one clock edge, updating the model with what the edge should do.
   task automatic tick();
      int   k;
      bit   rdy;
      ent_t e;
      k   = model_k(hold);
      rdy = (16 - mq.size()) >= 2;
      @(posedge clk);
      if (rst) begin
         mq.delete();
      end else begin
         for (int j = 0; j < k; j++) void'(mq.pop_front());
         if (rdy) begin
            for (int i = 0; i < 2; i++) begin
               if (in_vld[i]) begin
                  e.t = in_trgt[i*5 +: 5];
                  e.d = in_dat[i*32 +: 32];
                  mq.push_back(e);
               end
            end
         end
      end
      #1;
   endtask

   task automatic set_port(input int i, input logic [4:0] t, input logic [31:0] d);
      in_trgt[i*5 +: 5]  = t;
      in_dat[i*32 +: 32] = d;
   endtask

   task automatic test_reset();
      rst = 1'b1; hold = 1'b0; in_vld = 2'b11; in_trgt = '1; in_dat = '1;
      tick(); tick();
      rst = 1'b0; in_vld = 2'b00;
      #1;
      total++; if (we !== 4'b0000) begin bad++; $display("FAIL reset_we got=%b want=0000", we); end
      total++; if (pending !== 32'h0) begin bad++; $display("FAIL reset_pending got=%h want=0", pending); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
      total++; if (in_rdy !== 1'b1) begin bad++; $display("FAIL reset_in_rdy got=%b want=1", in_rdy); end
      total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (wr_trgt !== 20'h0 || wr_dat !== 128'h0) begin bad++; $display("FAIL reset_wr got=%h/%h want=0", wr_trgt, wr_dat); end
   endtask

   task automatic test_single_write();
      hold = 1'b0; in_vld = 2'b01; set_port(0, 5'd3, 32'hDEAD_BEEF);
      tick();
      in_vld = 2'b00;
      #1;
      total++; if (we !== 4'b0001) begin bad++; $display("FAIL single_we got=%b want=0001", we); end
      total++; if (wr_trgt[4:0] !== 5'd3) begin bad++; $display("FAIL single_trgt got=%0d want=3", wr_trgt[4:0]); end
      total++; if (wr_dat[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_dat got=%h want=deadbeef", wr_dat[31:0]); end
      total++; if (pending[3] !== 1'b1) begin bad++; $display("FAIL single_pending got=%b want=1", pending[3]); end
      total++; if (count !== 5'd1) begin bad++; $display("FAIL single_count got=%0d want=1", count); end
      tick();
      total++; if (count !== 5'd0 || empty !== 1'b1 || pending !== 32'h0) begin
         bad++; $display("FAIL single_drained got=count%0d empty%b pend%h want=0/1/0", count, empty, pending);
      end
   endtask

   task automatic test_fill_drain();
      hold = 1'b1;
      for (int c = 0; c < 8; c++) begin
         in_vld = 2'b11;
         set_port(0, 5'(2*c),     32'(100 + 2*c));
         set_port(1, 5'(2*c + 1), 32'(101 + 2*c));
         tick();
      end
      total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_count got=%0d want=16", count); end
      total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL fill_in_rdy got=%b want=0", in_rdy); end
      set_port(0, 5'd20, 32'hBAD0); set_port(1, 5'd21, 32'hBAD1);
      tick();
      total++; if (count !== 5'd16) begin bad++; $display("FAIL fill_dropped got=%0d want=16", count); end
      in_vld = 2'b00; hold = 1'b0;
      #1;
      for (int c = 0; c < 4; c++) begin
         total++; if (we !== 4'b1111) begin bad++; $display("FAIL drain_we c%0d got=%b want=1111", c, we); end
         for (int j = 0; j < 4; j++) begin
            total++;
            if (wr_trgt[j*5 +: 5] !== 5'(4*c + j) || wr_dat[j*32 +: 32] !== 32'(100 + 4*c + j)) begin
               bad++; $display("FAIL drain_order c%0d p%0d got=%0d/%0d want=%0d/%0d", c, j,
                               wr_trgt[j*5 +: 5], wr_dat[j*32 +: 32], 4*c + j, 100 + 4*c + j);
            end
         end
         tick();
      end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
   endtask

   task automatic test_dup_target();
      hold = 1'b1;
      in_vld = 2'b11; set_port(0, 5'd5, 32'd1); set_port(1, 5'd5, 32'd2);
      tick();
      in_vld = 2'b01; set_port(0, 5'd6, 32'd3);
      tick();
      in_vld = 2'b00; hold = 1'b0;
      #1;
      total++; if (we !== 4'b0001 || wr_trgt[4:0] !== 5'd5 || wr_dat[31:0] !== 32'd1) begin
         bad++; $display("FAIL dup_c1 got=%b/%0d/%0d want=0001/5/1", we, wr_trgt[4:0], wr_dat[31:0]);
      end
      tick();
      total++; if (we !== 4'b0011 || wr_trgt[9:0] !== {5'd6, 5'd5} || wr_dat[63:0] !== {32'd3, 32'd2}) begin
         bad++; $display("FAIL dup_c2 got=%b/%h/%h want=0011/(5,2)(6,3)", we, wr_trgt[9:0], wr_dat[63:0]);
      end
      total++; if (pending[5] !== 1'b1) begin bad++; $display("FAIL dup_pend_during got=%b want=1", pending[5]); end
      tick();
      total++; if (pending[5] !== 1'b0 || empty !== 1'b1) begin
         bad++; $display("FAIL dup_pend_after got=%b/%b want=0/1", pending[5], empty);
      end
   endtask

   task automatic test_sparse();
      hold = 1'b0; in_vld = 2'b10; set_port(0, 5'd30, 32'hFFFF); set_port(1, 5'd7, 32'd9);
      tick();
      in_vld = 2'b00;
      #1;
      total++; if (count !== 5'd1 || we !== 4'b0001) begin bad++; $display("FAIL sparse_cnt_we got=%0d/%b want=1/0001", count, we); end
      total++; if (wr_trgt[4:0] !== 5'd7 || wr_dat[31:0] !== 32'd9) begin
         bad++; $display("FAIL sparse_data got=%0d/%0d want=7/9", wr_trgt[4:0], wr_dat[31:0]);
      end
      tick();
   endtask

   task automatic test_wrap_random();
      ent_t sent[$];
      ent_t seen[$];
      ent_t e;
      int   to_send = 40;
      int   cyc = 0;
      int   k;
      bit   ok = 1'b1;
      hold = 1'b0;
      while (seen.size() < 40 && cyc < 400) begin
         if (cyc % 3 == 0 && cyc != 0) hold = ~hold;
         in_vld = 2'b00;
         if (to_send >= 2 && (16 - mq.size()) >= 2) begin
            in_vld = 2'b11;
            for (int i = 0; i < 2; i++) begin
               e.t = 5'($urandom_range(0, 7));
               e.d = $urandom;
               set_port(i, e.t, e.d);
               sent.push_back(e);
            end
            to_send -= 2;
         end
         #1;
         k = model_k(hold);
         if (count !== 5'(mq.size()) || count > 5'd16) ok = 1'b0;
         if (in_rdy !== ((16 - mq.size()) >= 2)) ok = 1'b0;
         if (we !== 4'((1 << k) - 1)) ok = 1'b0;
         if (pending !== model_pending()) ok = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if (j < k) begin
               if (wr_trgt[j*5 +: 5] !== mq[j].t || wr_dat[j*32 +: 32] !== mq[j].d) ok = 1'b0;
            end else if (wr_trgt[j*5 +: 5] !== 5'd0 || wr_dat[j*32 +: 32] !== 32'd0) begin
               ok = 1'b0;
            end
            if (we[j] === 1'b1) begin
               e.t = wr_trgt[j*5 +: 5];
               e.d = wr_dat[j*32 +: 32];
               seen.push_back(e);
            end
         end
         tick();
         cyc++;
      end
      in_vld = 2'b00; hold = 1'b0;
      total++; if (!ok) begin bad++; $display("FAIL wrap_cycle_model got=mismatching outputs want=model outputs"); end
      total++; if (seen.size() != 40) begin bad++; $display("FAIL wrap_timeout got=%0d writes want=40", seen.size()); end
      total++;
      begin
         int err = 0;
         for (int i = 0; i < 40 && i < seen.size(); i++) begin
            if (seen[i].t !== sent[i].t || seen[i].d !== sent[i].d) err++;
         end
         if (err != 0) begin bad++; $display("FAIL wrap_order got=%0d misordered want=0", err); end
      end
      tick();
   endtask

   task automatic test_reset_mid();
      hold = 1'b1;
      for (int c = 0; c < 5; c++) begin
         in_vld = (c == 4) ? 2'b01 : 2'b11;
         set_port(0, 5'(c), 32'(c));
         set_port(1, 5'(c + 10), 32'(c + 10));
         tick();
      end
      total++; if (count !== 5'd9) begin bad++; $display("FAIL mid_pre_count got=%0d want=9", count); end
      rst = 1'b1; in_vld = 2'b11;
      tick();
      rst = 1'b0; in_vld = 2'b00; hold = 1'b0;
      #1;
      total++; if (count !== 5'd0 || we !== 4'b0000 || pending !== 32'h0 || in_rdy !== 1'b1) begin
         bad++; $display("FAIL mid_reset got=count%0d we%b pend%h rdy%b want=0/0/0/1", count, we, pending, in_rdy);
      end
   endtask

   initial begin
      rst = 1'b1; hold = 1'b0; in_vld = '0; in_trgt = '0; in_dat = '0;
      test_reset();
      test_single_write();
      test_fill_drain();
      test_dup_target();
      test_sparse();
      test_wrap_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
